// File: rtl/bcd_converter_seq_pkg.sv
// Shared types for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Request/result bundle between a display-layer client and the converter.
interface bcd_converter_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow, blank
  );

endinterface

// File: rtl/bcd_converter_seq_digit_adjust.sv
// One BCD digit of the add-3 correction applied before every doubling shift.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_converter_seq.sv
// Bit-serial shift-and-add-3 binary-to-BCD converter with saturation on overflow
// and a leading-zero blanking mask for the 7-segment drivers.
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  bcd_converter_seq_if.slave bus
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int WW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]   binSr_q, binSr_d;
  logic [WW-1:0]      work_q, work_d;
  logic               ovf_q, ovf_d;
  logic [WW-1:0]      bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic [WW-1:0]      adjusted;
  logic               lastShift;
  logic               allZero;

  for (genvar g = 0; g < DIGITS; g++) begin : gAdjust
    bcd_digit_adjust uAdjust (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (adjusted[4*g +: 4])
    );
  end

  assign lastShift = (state_q == SHIFT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == SHIFT);
    bus.done     = (state_q == FINISH);
    bus.bcd      = bcd_q;
    bus.overflow = overflow_q;
    bus.blank    = blank_q;
  end

  // Work register and sticky overflow advance one input bit per SHIFT cycle.
  always_comb begin
    cnt_d   = cnt_q;
    binSr_d = binSr_q;
    work_d  = work_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && bus.start) begin
      binSr_d = bus.bin;
      work_d  = '0;
      ovf_d   = 1'b0;
      cnt_d   = CW'(BIN_W - 1);
    end else if (state_q == SHIFT) begin
      work_d  = {adjusted[WW-2:0], binSr_q[BIN_W-1]};
      binSr_d = binSr_q << 1;
      ovf_d   = ovf_q | adjusted[WW-1];
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Results are latched on the edge into FINISH so they are valid alongside done.
  always_comb begin
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    blank_d    = blank_q;
    allZero    = 1'b1;
    if (lastShift) begin
      bcd_d      = ovf_d ? {DIGITS{BCD_NINE}} : work_d;
      overflow_d = ovf_d;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        allZero    = allZero && (bcd_d[4*d +: 4] == 4'd0);
        blank_d[d] = allZero;
      end
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      binSr_q    <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      blank_q    <= BLANK_RST;
    end else begin
      cnt_q      <= cnt_d;
      binSr_q    <= binSr_d;
      work_q     <= work_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      blank_q    <= blank_d;
    end
  end

endmodule
